// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and latency helper for the modular-exponentiation engine
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE, PRE_M, PRE_X, SQR, MUL, POST, DONE
  } state_e;

  // Operand pair fed to the multiplier, named as A_B
  typedef enum logic [2:0] {
    OP_NONE, OP_M_CONST, OP_CONST_ONE, OP_X_X, OP_X_MB, OP_X_ONE
  } op_sel_e;

  // Cycles from the accepting edge to the eoc edge for an odd modulus
  function automatic int unsigned modexp_cycles(input int unsigned e, input int unsigned width,
                                                input int unsigned exp_width, input bit skip_lz);
    int unsigned scan;
    int unsigned ones;
    scan = 0;
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(exp_width) && e[i]) begin
        ones++;
        scan = 32'(i + 1);
      end
    end
    if (!skip_lz && ones != 0) scan = exp_width;
    return (3 + scan + ones) * (width + 3) + 1;
  endfunction

endpackage

// File: rtl/rsa_mont_mul.sv
// rtl/rsa_mont_mul.sv - bit-serial Montgomery multiplier, R = A*B*2^-WIDTH mod N
module rsa_mont_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic             done,
  output logic [WIDTH-1:0] R
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic [WIDTH+1:0] s_q, s_d, s_add, s_odd;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d, fin_q, fin_d, done_q, done_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    s_d    = s_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    fin_d  = fin_q;
    done_d = 1'b0;
    s_add  = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    s_odd  = s_add[0] ? s_add + {2'b00, n_q} : s_add;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      n_d   = '0;
      s_d   = '0;
      cnt_d = '0;
      run_d = 1'b0;
      fin_d = 1'b0;
    end else if (start) begin
      a_d   = A;
      b_d   = B;
      n_d   = N;
      s_d   = '0;
      cnt_d = '0;
      run_d = 1'b1;
      fin_d = 1'b0;
    end else if (run_q) begin
      s_d   = s_odd >> 1;
      a_d   = a_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        run_d = 1'b0;
        fin_d = 1'b1;
      end
    end else if (fin_q) begin
      // S < 2N here, so one conditional subtract fully reduces it
      if (s_q >= {2'b00, n_q}) s_d = s_q - {2'b00, n_q};
      fin_d  = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      fin_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (en) begin
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      fin_q  <= fin_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign R    = s_q[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_engine.sv
// rtl/rsa_modexp_engine.sv - Montgomery modular exponentiation C = M^E mod P
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8,
  parameter bit SKIP_LZ   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 irq_clr,
  input  logic [WIDTH-1:0]     P,
  input  logic [EXP_WIDTH-1:0] E,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Const,
  output logic [WIDTH-1:0]     C,
  output logic                 busy,
  output logic                 eoc,
  output logic                 irq,
  output logic                 err
);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  state_e               state_q, state_d;
  op_sel_e              op_sel;
  logic [WIDTH-1:0]     p_q, p_d, m_q, m_d, k_q, k_d, x_q, x_d, mb_q, mb_d, c_q, c_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [IW-1:0]        bit_q, bit_d, top_idx;
  logic                 pend_q, pend_d, busy_q, busy_d, eoc_q, eoc_d;
  logic                 irq_q, irq_d, err_q, err_d;
  logic                 accept, abort, mm_start, mm_clr, mm_done;
  logic [WIDTH-1:0]     mm_a, mm_b, mm_r;

  assign accept = (state_q == IDLE) && start && !stop;
  assign abort  = (state_q != IDLE) && stop;

  always_comb begin
    top_idx = IW'(EXP_WIDTH - 1);
    if (SKIP_LZ) begin
      top_idx = '0;
      for (int i = 0; i < EXP_WIDTH; i++) begin
        if (E[i]) top_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (P[0]) state_d = PRE_M;
          else      state_d = DONE;
          bit_d = top_idx;
        end
      end
      PRE_M: if (mm_done) state_d = PRE_X;
      PRE_X: begin
        if (mm_done) begin
          if (e_q == '0) state_d = POST;
          else           state_d = SQR;
        end
      end
      SQR: begin
        if (mm_done) begin
          if (e_q[bit_q])          state_d = MUL;
          else if (bit_q == '0)    state_d = POST;
          else                     bit_d   = bit_q - 1'b1;
        end
      end
      MUL: begin
        if (mm_done) begin
          if (bit_q == '0) state_d = POST;
          else begin
            state_d = SQR;
            bit_d   = bit_q - 1'b1;
          end
        end
      end
      POST:    if (mm_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    mm_start = pend_q;
    mm_clr   = abort;
    case (state_q)
      PRE_M:   op_sel = OP_M_CONST;
      PRE_X:   op_sel = OP_CONST_ONE;
      SQR:     op_sel = OP_X_X;
      MUL:     op_sel = OP_X_MB;
      POST:    op_sel = OP_X_ONE;
      default: op_sel = OP_NONE;
    endcase
  end

  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (op_sel)
      OP_M_CONST:   begin mm_a = m_q; mm_b = k_q;              end
      OP_CONST_ONE: begin mm_a = k_q; mm_b = WIDTH'(1);        end
      OP_X_X:       begin mm_a = x_q; mm_b = x_q;              end
      OP_X_MB:      begin mm_a = x_q; mm_b = mb_q;             end
      OP_X_ONE:     begin mm_a = x_q; mm_b = WIDTH'(1);        end
      default:      begin mm_a = '0;  mm_b = '0;               end
    endcase
  end

  rsa_mont_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst(rst), .en(en), .clr(mm_clr), .start(mm_start),
    .A(mm_a), .B(mm_b), .N(p_q), .done(mm_done), .R(mm_r)
  );

  always_comb begin
    p_d    = p_q;
    e_d    = e_q;
    m_d    = m_q;
    k_d    = k_q;
    x_d    = x_q;
    mb_d   = mb_q;
    c_d    = c_q;
    busy_d = busy_q;
    err_d  = err_q;
    irq_d  = irq_q;
    eoc_d  = 1'b0;
    if (accept) begin
      p_d    = P;
      e_d    = E;
      m_d    = M;
      k_d    = Const;
      x_d    = '0;
      mb_d   = '0;
      busy_d = 1'b1;
      err_d  = 1'b0;
    end
    if (mm_done && !abort) begin
      if (state_q == PRE_M) mb_d = mm_r;
      else                  x_d  = mm_r;
    end
    if (state_q == DONE && !abort) begin
      c_d    = p_q[0] ? x_q : '0;
      err_d  = !p_q[0];
      busy_d = 1'b0;
      eoc_d  = 1'b1;
    end
    if (abort) busy_d = 1'b0;
    if (irq_clr || accept) irq_d = 1'b0;
    if (eoc_d) irq_d = 1'b1;
    // the next multiply is launched the cycle after the previous one reports done
    pend_d = !abort && (accept || mm_done) && (state_d inside {PRE_M, PRE_X, SQR, MUL, POST});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q    <= '0;
      e_q    <= '0;
      m_q    <= '0;
      k_q    <= '0;
      x_q    <= '0;
      mb_q   <= '0;
      c_q    <= '0;
      pend_q <= 1'b0;
      busy_q <= 1'b0;
      eoc_q  <= 1'b0;
      irq_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (en) begin
      p_q    <= p_d;
      e_q    <= e_d;
      m_q    <= m_d;
      k_q    <= k_d;
      x_q    <= x_d;
      mb_q   <= mb_d;
      c_q    <= c_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      eoc_q  <= eoc_d;
      irq_q  <= irq_d;
      err_q  <= err_d;
    end
  end

  assign C    = c_q;
  assign busy = busy_q;
  assign eoc  = eoc_q;
  assign irq  = irq_q;
  assign err  = err_q;

endmodule
